// File: rtl/reservation_station_pkg.sv
// Shared widths, default sizing and inner instruction-type encodings for the
// reservation station slice.
package reservation_station_pkg;

    localparam int INST_W          = 6;
    localparam int WORD_W          = 32;
    localparam int ROB_TAG_W       = 4;
    localparam int RS_SIZE_DEFAULT = 16;

    typedef enum logic [INST_W-1:0] {
        INST_NOP = 6'd0,
        INST_ADD = 6'd1,
        INST_SUB = 6'd2,
        INST_AND = 6'd3,
        INST_OR  = 6'd4,
        INST_XOR = 6'd5,
        INST_SLL = 6'd6,
        INST_SRL = 6'd7,
        INST_BEQ = 6'd8
    } inst_e;

endpackage

// File: rtl/reservation_station_rs_select.sv
// rs_select: combinational lowest-index priority encoder with a found flag.
module rs_select #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     req_in,
    output logic             found_out,
    output logic [IDX_W-1:0] idx_out
);

    // Scan downwards so the last hit written is the lowest set request.
    always_comb begin
        found_out = 1'b0;
        idx_out   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_in[i]) begin
                found_out = 1'b1;
                idx_out   = IDX_W'(i);
            end else begin
                found_out = found_out;
                idx_out   = idx_out;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// reservation_station: dispatch/snoop/issue buffer feeding the ALU.
// Optional macro RS_CDB_BYPASS_EN captures a same-cycle CDB broadcast at dispatch.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEFAULT,
    parameter int TAG_W   = ROB_TAG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy_in,
    input  logic              clear_in,
    input  logic              new_inst_in,
    input  logic [INST_W-1:0] inst_in,
    input  logic [WORD_W-1:0] imm_in,
    input  logic [WORD_W-1:0] pc_in,
    input  logic [TAG_W-1:0]  dest_in,
    input  logic [WORD_W-1:0] v1_in,
    input  logic [WORD_W-1:0] v2_in,
    input  logic [TAG_W-1:0]  q1_in,
    input  logic [TAG_W-1:0]  q2_in,
    input  logic              q1_rdy_in,
    input  logic              q2_rdy_in,
    input  logic              cdb_valid_in,
    input  logic [TAG_W-1:0]  cdb_tag_in,
    input  logic [WORD_W-1:0] cdb_value_in,
    output logic              full_out,
    output logic              alu_valid_out,
    output logic [INST_W-1:0] alu_inst_out,
    output logic [WORD_W-1:0] alu_v1_out,
    output logic [WORD_W-1:0] alu_v2_out,
    output logic [WORD_W-1:0] alu_imm_out,
    output logic [WORD_W-1:0] alu_pc_out,
    output logic [TAG_W-1:0]  alu_dest_out
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    typedef struct packed {
        logic              busy;
        logic [INST_W-1:0] inst;
        logic [WORD_W-1:0] v1;
        logic [WORD_W-1:0] v2;
        logic [TAG_W-1:0]  q1;
        logic [TAG_W-1:0]  q2;
        logic              r1;
        logic              r2;
        logic [WORD_W-1:0] imm;
        logic [WORD_W-1:0] pc;
        logic [TAG_W-1:0]  dest;
    } entry_t;

    entry_t ent_q [RS_SIZE];
    entry_t ent_d [RS_SIZE];
    entry_t new_ent_s;

    logic [RS_SIZE-1:0] free_vec_s;
    logic [RS_SIZE-1:0] ready_vec_s;
    logic               free_found_s;
    logic               ready_found_s;
    logic [IDX_W-1:0]   free_idx_s;
    logic [IDX_W-1:0]   ready_idx_s;

    logic              alu_valid_q, alu_valid_d;
    logic [INST_W-1:0] alu_inst_q, alu_inst_d;
    logic [WORD_W-1:0] alu_v1_q, alu_v1_d;
    logic [WORD_W-1:0] alu_v2_q, alu_v2_d;
    logic [WORD_W-1:0] alu_imm_q, alu_imm_d;
    logic [WORD_W-1:0] alu_pc_q, alu_pc_d;
    logic [TAG_W-1:0]  alu_dest_q, alu_dest_d;

    // Free/ready request vectors come from registered state only.
    always_comb begin
        free_vec_s  = '0;
        ready_vec_s = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            free_vec_s[i]  = ~ent_q[i].busy;
            ready_vec_s[i] = ent_q[i].busy & ent_q[i].r1 & ent_q[i].r2;
        end
    end

    assign full_out = ~free_found_s;

    rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_sel (
        .req_in    (free_vec_s),
        .found_out (free_found_s),
        .idx_out   (free_idx_s)
    );

    rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_ready_sel (
        .req_in    (ready_vec_s),
        .found_out (ready_found_s),
        .idx_out   (ready_idx_s)
    );

    // Entry image written on dispatch.
    always_comb begin
        new_ent_s      = '0;
        new_ent_s.busy = 1'b1;
        new_ent_s.inst = inst_in;
        new_ent_s.q1   = q1_in;
        new_ent_s.q2   = q2_in;
        new_ent_s.imm  = imm_in;
        new_ent_s.pc   = pc_in;
        new_ent_s.dest = dest_in;
`ifdef RS_CDB_BYPASS_EN
        new_ent_s.r1 = q1_rdy_in | (cdb_valid_in & (q1_in == cdb_tag_in));
        new_ent_s.r2 = q2_rdy_in | (cdb_valid_in & (q2_in == cdb_tag_in));
        new_ent_s.v1 = (!q1_rdy_in && cdb_valid_in && (q1_in == cdb_tag_in)) ? cdb_value_in : v1_in;
        new_ent_s.v2 = (!q2_rdy_in && cdb_valid_in && (q2_in == cdb_tag_in)) ? cdb_value_in : v2_in;
`else
        new_ent_s.r1 = q1_rdy_in;
        new_ent_s.r2 = q2_rdy_in;
        new_ent_s.v1 = v1_in;
        new_ent_s.v2 = v2_in;
`endif
    end

    // Next state: clear beats the rdy gate, which beats snoop/issue/dispatch.
    always_comb begin
        ent_d       = ent_q;
        alu_valid_d = alu_valid_q;
        alu_inst_d  = alu_inst_q;
        alu_v1_d    = alu_v1_q;
        alu_v2_d    = alu_v2_q;
        alu_imm_d   = alu_imm_q;
        alu_pc_d    = alu_pc_q;
        alu_dest_d  = alu_dest_q;
        if (clear_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_d[i].busy = 1'b0;
            end
            alu_valid_d = 1'b0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (ent_q[i].busy && !ent_q[i].r1 && cdb_valid_in && (ent_q[i].q1 == cdb_tag_in)) begin
                    ent_d[i].v1 = cdb_value_in;
                    ent_d[i].r1 = 1'b1;
                end else begin
                    ent_d[i].r1 = ent_q[i].r1;
                end
                if (ent_q[i].busy && !ent_q[i].r2 && cdb_valid_in && (ent_q[i].q2 == cdb_tag_in)) begin
                    ent_d[i].v2 = cdb_value_in;
                    ent_d[i].r2 = 1'b1;
                end else begin
                    ent_d[i].r2 = ent_q[i].r2;
                end
            end
            if (ready_found_s) begin
                alu_valid_d              = 1'b1;
                alu_inst_d               = ent_q[ready_idx_s].inst;
                alu_v1_d                 = ent_q[ready_idx_s].v1;
                alu_v2_d                 = ent_q[ready_idx_s].v2;
                alu_imm_d                = ent_q[ready_idx_s].imm;
                alu_pc_d                 = ent_q[ready_idx_s].pc;
                alu_dest_d               = ent_q[ready_idx_s].dest;
                ent_d[ready_idx_s].busy  = 1'b0;
            end else begin
                alu_valid_d = 1'b0;
            end
            // The free slot is never the issuing slot, so the two writes cannot collide.
            if (new_inst_in && free_found_s) begin
                ent_d[free_idx_s] = new_ent_s;
            end else begin
                alu_dest_d = alu_dest_d;
            end
        end else begin
            ent_d       = ent_q;
            alu_valid_d = alu_valid_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= '0;
            end
            alu_valid_q <= 1'b0;
            alu_inst_q  <= '0;
            alu_v1_q    <= '0;
            alu_v2_q    <= '0;
            alu_imm_q   <= '0;
            alu_pc_q    <= '0;
            alu_dest_q  <= '0;
        end else begin
            ent_q       <= ent_d;
            alu_valid_q <= alu_valid_d;
            alu_inst_q  <= alu_inst_d;
            alu_v1_q    <= alu_v1_d;
            alu_v2_q    <= alu_v2_d;
            alu_imm_q   <= alu_imm_d;
            alu_pc_q    <= alu_pc_d;
            alu_dest_q  <= alu_dest_d;
        end
    end

    assign alu_valid_out = alu_valid_q;
    assign alu_inst_out  = alu_inst_q;
    assign alu_v1_out    = alu_v1_q;
    assign alu_v2_out    = alu_v2_q;
    assign alu_imm_out   = alu_imm_q;
    assign alu_pc_out    = alu_pc_q;
    assign alu_dest_out  = alu_dest_q;

endmodule
